// File: rtl/gc_table_sink.sv
// gc_table_sink: back end of the AND-gate garbling engine.
// Follows each issued gate through the fixed-latency engine, writes its output label
// to label memory and buffers its garbled table (t0,t1) in a FIFO. Tables leave as two
// K-bit words (t0 then t1) on a ready/valid stream. A credit counter guarantees that
// every issued gate has a FIFO slot, because the engine itself cannot stall.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   gate_issue, gate_gid              gate entering the engine this cycle, and its gid
//   t0, t1, out_label                 engine results, valid LAT cycles after issue
//   issue_ok                          credit available; upstream issues only when 1
//   lbl_we, lbl_addr, lbl_data        label memory write port (one pulse per gate)
//   tbl_valid/data/last, tbl_ready    table word stream; tbl_last marks the t1 word
//   tbl_count                         FIFO occupancy in tables
//   overflow                          sticky protocol-violation / dropped-table flag
module gc_table_sink #(
    parameter int unsigned K     = 128,
    parameter int unsigned S     = 20,
    parameter int unsigned LAT   = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gate_issue,
    input  logic [S-1:0]               gate_gid,
    input  logic [K-1:0]               t0,
    input  logic [K-1:0]               t1,
    input  logic [K-1:0]               out_label,
    output logic                       issue_ok,
    output logic                       lbl_we,
    output logic [S-1:0]               lbl_addr,
    output logic [K-1:0]               lbl_data,
    output logic                       tbl_valid,
    output logic [K-1:0]               tbl_data,
    output logic                       tbl_last,
    input  logic                       tbl_ready,
    output logic [$clog2(DEPTH+1)-1:0] tbl_count,
    output logic                       overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Tracking pipe: stage LAT-1 lines up with the engine outputs for the same gate.
    logic [LAT-1:0] pipe_v_q, pipe_v_d;
    logic [S-1:0]   pipe_gid_q [LAT];
    logic [S-1:0]   pipe_gid_d [LAT];

    logic [CW-1:0]  credits_q, credits_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           half_q, half_d;
    logic           ovf_q, ovf_d;
    logic           lbl_we_q, lbl_we_d;
    logic [S-1:0]   lbl_addr_q, lbl_addr_d;
    logic [K-1:0]   lbl_data_q, lbl_data_d;

    // Each entry holds {t0, t1}; storage carries no reset, reads are gated by tbl_valid.
    logic [2*K-1:0] mem_q [DEPTH];
    logic [2*K-1:0] head;

    logic arrive, full, empty, accept, pop, push, drop;

    // Next-state logic for the pipe, FIFO, serializer, credits and label port.
    always_comb begin
        pipe_v_d      = pipe_v_q;
        pipe_gid_d    = pipe_gid_q;
        credits_d     = credits_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        half_d        = half_q;
        ovf_d         = ovf_q;
        lbl_we_d      = 1'b0;
        lbl_addr_d    = lbl_addr_q;
        lbl_data_d    = lbl_data_q;

        pipe_v_d[0]   = gate_issue;
        pipe_gid_d[0] = gate_gid;
        for (int i = 1; i < int'(LAT); i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_gid_d[i] = pipe_gid_q[i-1];
        end

        arrive = pipe_v_q[LAT-1];
        full   = (cnt_q == CW'(DEPTH));
        empty  = (cnt_q == '0);
        accept = !empty && tbl_ready;
        pop    = accept && half_q;
        // A full FIFO still takes the arrival when the head leaves in the same cycle.
        push   = arrive && (!full || pop);
        drop   = arrive && full && !pop;

        if (arrive) begin
            lbl_we_d   = 1'b1;
            lbl_addr_d = pipe_gid_q[LAT-1];
            lbl_data_d = out_label;
        end

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      cnt_d = cnt_q + CW'(1);
        else if (pop && !push) cnt_d = cnt_q - CW'(1);

        if (accept) half_d = !half_q;

        // A returning credit and a new issue in the same cycle cancel out.
        if (gate_issue && !pop) begin
            if (credits_q != '0) credits_d = credits_q - CW'(1);
        end else if (pop && !gate_issue) begin
            if (credits_q != CW'(DEPTH)) credits_d = credits_q + CW'(1);
        end

        if ((gate_issue && credits_q == '0) || drop) ovf_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v_q   <= '0;
            for (int i = 0; i < int'(LAT); i++) pipe_gid_q[i] <= '0;
            credits_q  <= CW'(DEPTH);
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            half_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lbl_we_q   <= 1'b0;
            lbl_addr_q <= '0;
            lbl_data_q <= '0;
        end else begin
            pipe_v_q   <= pipe_v_d;
            pipe_gid_q <= pipe_gid_d;
            credits_q  <= credits_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            half_q     <= half_d;
            ovf_q      <= ovf_d;
            lbl_we_q   <= lbl_we_d;
            lbl_addr_q <= lbl_addr_d;
            lbl_data_q <= lbl_data_d;
        end
    end

    // Table storage write port.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {t0, t1};
    end

    // Outputs decoded from registered state only.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        issue_ok  = (credits_q != '0);
        tbl_valid = (cnt_q != '0);
        tbl_last  = tbl_valid && half_q;
        tbl_data  = '0;
        if (tbl_valid) tbl_data = half_q ? head[K-1:0] : head[2*K-1:K];
    end

    assign lbl_we    = lbl_we_q;
    assign lbl_addr  = lbl_addr_q;
    assign lbl_data  = lbl_data_q;
    assign tbl_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_gc_table_sink.sv
// Directed bench for gc_table_sink with LAT=10, DEPTH=4. A small engine stub presents
// gid-tagged t0/t1/label values exactly LAT cycles after each issue and noise otherwise.
module tb_gc_table_sink;

    localparam int unsigned K     = 128;
    localparam int unsigned S     = 20;
    localparam int unsigned LAT   = 10;
    localparam int unsigned DEPTH = 4;

    logic         clk, rst;
    logic         gate_issue;
    logic [S-1:0] gate_gid;
    logic [K-1:0] t0, t1, out_label;
    logic         issue_ok, lbl_we, tbl_valid, tbl_last, tbl_ready, overflow;
    logic [S-1:0] lbl_addr;
    logic [K-1:0] lbl_data, tbl_data;
    logic [2:0]   tbl_count;

    gc_table_sink #(.K(K), .S(S), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .gate_issue(gate_issue), .gate_gid(gate_gid),
        .t0(t0), .t1(t1), .out_label(out_label), .issue_ok(issue_ok),
        .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data),
        .tbl_valid(tbl_valid), .tbl_data(tbl_data), .tbl_last(tbl_last),
        .tbl_ready(tbl_ready), .tbl_count(tbl_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int issue; int gid; int ready;
        int ok; int we; int addr;
        int tv; int tl; int tgid;
        int cnt; int ovf;
    } vec_t;

    vec_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic eng_v [LAT];
    int   eng_g [LAT];
    int   nxt, el, et, eh, bad;

    function automatic logic [K-1:0] t0_of(input int g);
        logic [19:0] g20 = 20'(g);
        return {4{8'hA0, 4'h0, g20}};
    endfunction
    function automatic logic [K-1:0] t1_of(input int g);
        logic [19:0] g20 = 20'(g);
        return {4{8'hB1, 4'h0, g20}};
    endfunction
    function automatic logic [K-1:0] lbl_of(input int g);
        logic [19:0] g20 = 20'(g);
        return {4{8'hC2, 4'h0, g20}};
    endfunction

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Close the current cycle; the engine stub advances with the inputs just sampled.
    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = int'(LAT) - 1; i > 0; i--) begin
            eng_v[i] = eng_v[i-1];
            eng_g[i] = eng_g[i-1];
        end
        eng_v[0] = gate_issue;
        eng_g[0] = int'(gate_gid);
        if (eng_v[LAT-1]) begin
            t0        = t0_of(eng_g[LAT-1]);
            t1        = t1_of(eng_g[LAT-1]);
            out_label = lbl_of(eng_g[LAT-1]);
        end else begin
            t0        = {$urandom, $urandom, $urandom, $urandom};
            t1        = {$urandom, $urandom, $urandom, $urandom};
            out_label = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic chk_reset(input string tag);
        check({tag, ".ok"},    K'(issue_ok),  K'(1));
        check({tag, ".we"},    K'(lbl_we),    K'(0));
        check({tag, ".addr"},  K'(lbl_addr),  K'(0));
        check({tag, ".ldata"}, lbl_data,      K'(0));
        check({tag, ".tv"},    K'(tbl_valid), K'(0));
        check({tag, ".tdata"}, tbl_data,      K'(0));
        check({tag, ".tl"},    K'(tbl_last),  K'(0));
        check({tag, ".cnt"},   K'(tbl_count), K'(0));
        check({tag, ".ovf"},   K'(overflow),  K'(0));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        gate_issue = (v.issue != 0);
        gate_gid   = 20'(v.gid);
        tbl_ready  = (v.ready != 0);
        @(negedge clk);
        check({tag, ".ok"}, K'(issue_ok), K'(v.ok));
        check({tag, ".we"}, K'(lbl_we),   K'(v.we));
        if (v.we != 0) begin
            check({tag, ".addr"},  K'(lbl_addr), K'(v.addr));
            check({tag, ".ldata"}, lbl_data,     lbl_of(v.addr));
        end
        check({tag, ".tv"}, K'(tbl_valid), K'(v.tv));
        if (v.tv != 0) begin
            check({tag, ".tl"},    K'(tbl_last), K'(v.tl));
            check({tag, ".tdata"}, tbl_data, (v.tl != 0) ? t1_of(v.tgid) : t0_of(v.tgid));
        end
        check({tag, ".cnt"}, K'(tbl_count), K'(v.cnt));
        check({tag, ".ovf"}, K'(overflow),  K'(v.ovf));
        cyc();
    endtask

    task automatic run_queue(input string tag);
        foreach (q[i]) run_vec(q[i], $sformatf("%s[%0d]", tag, i));
        q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        gate_issue = 1'b0;
        tbl_ready  = 1'b0;
        cyc();
        @(negedge clk);
        chk_reset(tag);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gate_issue = 1'b0; gate_gid = '0; tbl_ready = 1'b0;
        t0 = '0; t1 = '0; out_label = '0;
        for (int i = 0; i < int'(LAT); i++) begin eng_v[i] = 1'b0; eng_g[i] = 0; end
        cyc();
        do_reset("rst0");

        // Single gate, gid 5, consumer always ready.
        q.push_back('{1,5,1, 1,0,0, 0,0,0, 0,0});
        for (int c = 1; c <= 10; c++) q.push_back('{0,0,1, 1,0,0, 0,0,0, 0,0});
        q.push_back('{0,0,1, 1,1,5, 1,0,5, 1,0});
        q.push_back('{0,0,1, 1,0,0, 1,1,5, 1,0});
        q.push_back('{0,0,1, 1,0,0, 0,0,0, 0,0});
        run_queue("t1");

        // Issue while credit lasts, consumer stalled: four tables fill the FIFO.
        for (int c = 0; c < 16; c++) begin
            gate_issue = (c < 4);
            gate_gid   = 20'(c);
            tbl_ready  = 1'b0;
            @(negedge clk);
            check($sformatf("t2[%0d].ok", c), K'(issue_ok), K'(c < 4));
            check($sformatf("t2[%0d].we", c), K'(lbl_we), K'(c >= 11 && c <= 14));
            if (c >= 11 && c <= 14) begin
                check($sformatf("t2[%0d].addr", c), K'(lbl_addr), K'(c - 11));
                check($sformatf("t2[%0d].ldata", c), lbl_data, lbl_of(c - 11));
            end
            check($sformatf("t2[%0d].cnt", c), K'(tbl_count),
                  K'((c < 11) ? 0 : ((c - 10 > 4) ? 4 : c - 10)));
            check($sformatf("t2[%0d].ovf", c), K'(overflow), K'(0));
            if (c == 15) begin
                check("t2.tv", K'(tbl_valid), K'(1));
                check("t2.tl", K'(tbl_last), K'(0));
                check("t2.tdata", tbl_data, t0_of(0));
            end
            cyc();
        end

        // Toggling ready, credit return, issue without credit, drop at full, drain.
        q.push_back('{0,0,1, 0,0,0, 1,0,0, 4,0});
        q.push_back('{0,0,0, 0,0,0, 1,1,0, 4,0});
        q.push_back('{0,0,1, 0,0,0, 1,1,0, 4,0});
        q.push_back('{1,4,0, 1,0,0, 1,0,1, 3,0});
        q.push_back('{0,0,1, 0,0,0, 1,0,1, 3,0});
        q.push_back('{0,0,0, 0,0,0, 1,1,1, 3,0});
        q.push_back('{0,0,1, 0,0,0, 1,1,1, 3,0});
        q.push_back('{1,5,0, 1,0,0, 1,0,2, 2,0});
        q.push_back('{1,6,0, 0,0,0, 1,0,2, 2,0});
        for (int c = 9; c <= 13; c++) q.push_back('{0,0,0, 0,0,0, 1,0,2, 2,1});
        q.push_back('{0,0,0, 0,1,4, 1,0,2, 3,1});
        for (int c = 15; c <= 17; c++) q.push_back('{0,0,0, 0,0,0, 1,0,2, 3,1});
        q.push_back('{0,0,0, 0,1,5, 1,0,2, 4,1});
        q.push_back('{0,0,0, 0,1,6, 1,0,2, 4,1});
        q.push_back('{0,0,0, 0,0,0, 1,0,2, 4,1});
        for (int j = 0; j < 8; j++)
            q.push_back('{0,0,1, int'(j >= 2),0,0, 1,j % 2,2 + j / 2, 4 - j / 2, 1});
        q.push_back('{0,0,1, 1,0,0, 0,0,0, 0,1});
        run_queue("t34");

        do_reset("rst1");

        // Sustained credit-limited issue of gids 0..20 with an always-ready consumer.
        nxt = 0; el = 0; et = 0; eh = 0;
        tbl_ready = 1'b1;
        for (int c = 0; c < 600 && et < 21; c++) begin
            gate_issue = issue_ok && (nxt <= 20);
            gate_gid   = 20'(nxt);
            if (gate_issue) nxt++;
            @(negedge clk);
            if (lbl_we) begin
                check($sformatf("t5.addr%0d", el), K'(lbl_addr), K'(el));
                check($sformatf("t5.ldata%0d", el), lbl_data, lbl_of(el));
                el++;
            end
            if (tbl_valid) begin
                check($sformatf("t5.tl%0d_%0d", et, eh), K'(tbl_last), K'(eh));
                check($sformatf("t5.tdata%0d_%0d", et, eh), tbl_data,
                      (eh != 0) ? t1_of(et) : t0_of(et));
                if (eh != 0) et++;
                eh ^= 1;
            end
            cyc();
        end
        gate_issue = 1'b0;
        check("t5.tables", K'(et), K'(21));
        check("t5.labels", K'(el), K'(21));
        check("t5.ovf", K'(overflow), K'(0));
        repeat (3) cyc();

        // Build 2 buffered tables and 3 gates in flight, then reset mid-cycle.
        q.push_back('{1,100,0, 1,0,0, 0,0,0, 0,0});
        q.push_back('{1,101,0, 1,0,0, 0,0,0, 0,0});
        for (int c = 2; c <= 10; c++) q.push_back('{0,0,0, 1,0,0, 0,0,0, 0,0});
        q.push_back('{0,0,0, 1,1,100, 1,0,100, 1,0});
        q.push_back('{1,102,0, 1,1,101, 1,0,100, 2,0});
        q.push_back('{1,103,0, 1,0,0, 1,0,100, 2,0});
        q.push_back('{1,104,0, 0,0,0, 1,0,100, 2,0});
        q.push_back('{0,0,0, 0,0,0, 1,0,100, 2,1});
        q.push_back('{0,0,0, 0,0,0, 1,0,100, 2,1});
        run_queue("t6");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset("t6.rst");
        cyc();
        rst = 1'b0;
        tbl_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (lbl_we || tbl_valid) bad++;
            cyc();
        end
        check("t6.stale", K'(bad), K'(0));
        check("t6.ok", K'(issue_ok), K'(1));
        check("t6.cnt", K'(tbl_count), K'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
